bmm_dmem_responder: RTL

Data-side memory responder for the bmm core's req/gnt/rvalid data port. It holds a byte-addressable word array and grants requests under a configurable outstanding-transaction limit. It returns in-order responses after a fixed latency, with optional out-of-range error signalling. It replaces the zero-latency behavioural data RAM in simulation and serves as the on-chip data memory in the SoC.

---
 rtl/bmm_dmem_pkg.sv | 20 ++
 rtl/bmm_dmem_array.sv | 35 +++
 rtl/bmm_dmem_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bmm_dmem_pkg.sv
// Shared types and helpers for the bmm data-memory responder.
package bmm_dmem_pkg;

  localparam int unsigned NUM_LANES   = 4;
  localparam int unsigned MAX_LATENCY = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;

  // Number of index bits needed to address every 32-bit word of the array.
  function automatic int unsigned word_idx_width(input int unsigned num_bytes);
    int unsigned words;
    words = num_bytes / NUM_LANES;
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/bmm_dmem_array.sv
// Single-port word array with byte-lane writes and a registered read port.
// Holds no reset so its contents survive a core reset.
module bmm_dmem_array
  import bmm_dmem_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 3072,
  parameter int unsigned IDX_W     = 12
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [NUM_LANES-1:0] be_i,
  input  logic [IDX_W-1:0]     idx_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem [NUM_WORDS];

  // Accepted access: merge enabled lanes on a write, capture the word on a read.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          if (be_i[k]) begin
            mem[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
          end
        end
      end else begin
        rdata_o <= mem[idx_i];
      end
    end
  end

endmodule

// File: rtl/bmm_dmem_responder.sv
// Data-side memory responder for the bmm core req/gnt/rvalid port.
// Grants under an outstanding-transaction limit and answers in order after
// LATENCY cycles. Define BMM_DMEM_ERR_EN to flag out-of-range accesses on err_o.
module bmm_dmem_responder
  import bmm_dmem_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH      = 32,
  parameter int unsigned            DATA_WIDTH      = 32,
  parameter int unsigned            NUM_BYTES       = 12288,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR       = 'h1000,
  parameter int unsigned            LATENCY         = 1,
  parameter int unsigned            MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [NUM_LANES-1:0]  be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  stall_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int unsigned IDX_W     = word_idx_width(NUM_BYTES);
  localparam int unsigned NUM_WORDS = NUM_BYTES / NUM_LANES;
  localparam int unsigned CNT_W     = 3;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic [IDX_W-1:0]      word_idx;
  logic                  acc_err;
  logic                  gnt;
  logic                  below_limit;
  logic [CNT_W-1:0]      cnt;
  logic [31:0]           arr_rdata;
  logic                  s0_valid;
  logic                  s0_rd;
  logic                  s0_err;
  dmem_rsp_t             stage0;
  dmem_rsp_t             rsp_out;

  // Offset wraps, so addresses below BASE_ADDR land far out of range.
  assign offset   = addr_i - BASE_ADDR;
  assign in_range = (offset < ADDR_WIDTH'(NUM_BYTES));
  assign word_idx = offset[IDX_W+1:2];

`ifdef BMM_DMEM_ERR_EN
  assign acc_err = ~in_range;
`else
  assign acc_err = 1'b0;
`endif

  // A retiring response frees a slot in the same cycle.
  assign below_limit = (cnt < CNT_W'(MAX_OUTSTANDING));
  assign gnt         = req_i & ~stall_i & ~rst_i & (below_limit | rsp_out.valid);
  assign gnt_o       = gnt;

  bmm_dmem_array #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (gnt & in_range),
    .we_i    (we_i),
    .be_i    (be_i),
    .idx_i   (word_idx),
    .wdata_i (wdata_i),
    .rdata_o (arr_rdata)
  );

  // Outstanding count: up on grant, down on response, both leave it unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else begin
      case ({gnt, rsp_out.valid})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Stage-0 control flags travel alongside the array's registered read word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_valid <= 1'b0;
      s0_rd    <= 1'b0;
      s0_err   <= 1'b0;
    end else begin
      s0_valid <= gnt;
      s0_rd    <= gnt & ~we_i & in_range;
      s0_err   <= gnt & acc_err;
    end
  end

  // Writes and out-of-range reads answer with zero data.
  always_comb begin
    stage0       = '0;
    stage0.valid = s0_valid;
    stage0.rdata = s0_rd ? arr_rdata : 32'h0;
    stage0.err   = s0_err;
  end

  if (LATENCY == 1) begin : g_direct
    assign rsp_out = stage0;
  end else begin : g_pipe
    dmem_rsp_t rsp_q [LATENCY-1];

    // Remaining response stages shift every cycle; reset drops anything in flight.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < LATENCY-1; i++) begin
          rsp_q[i] <= '0;
        end
      end else begin
        rsp_q[0] <= stage0;
        for (int i = 1; i < LATENCY-1; i++) begin
          rsp_q[i] <= rsp_q[i-1];
        end
      end
    end

    assign rsp_out = rsp_q[LATENCY-2];
  end

  assign rvalid_o = rsp_out.valid;
  assign rdata_o  = rsp_out.rdata;
  assign err_o    = rsp_out.err;

endmodule
